iic_master: RTL and testbench

- Parametrised I2C master byte engine, the successor to iic_core.
- Generates START, repeated START and STOP conditions, transfers one byte per command with ACK handling, and holds the bus between bytes.
- Drives SDA open-drain through a pull-low enable plus a sampled input, so it sits directly behind an IOBUF/pad.
- Adds a programmable SCL rate, read-ACK control, slave NACK detection and optional clock stretching.

---
 rtl/iic_master.sv | 276 +++++++++++++++++++++++++++
 tb/tb_iic_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/iic_master.sv
// I2C master byte engine: START/repeated START/STOP plus one byte per command, open-drain SDA.
// Define IIC_CLK_STRETCH_EN to let a slave stretch SCL by holding scl_in low.
module iic_master #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       restart,
    input  logic       stop,
    input  logic       rw,
    input  logic       ack_out,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       sending,
    output logic       held,
    output logic       done,
    output logic       ack_err,
    output logic       sck,
    output logic       sda_pull,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START_A = 4'd1,
        ST_START_B = 4'd2,
        ST_BIT     = 4'd3,
        ST_HOLD    = 4'd4,
        ST_RS_A    = 4'd5,
        ST_STOP_A  = 4'd6,
        ST_STOP_B  = 4'd7,
        ST_STOP_C  = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       dout_q, dout_d;
    logic             rw_q, rw_d;
    logic             ack_out_q, ack_out_d;
    logic             ack_bit_q, ack_bit_d;
    logic             sck_q, sck_d;
    logic             sda_pull_q, sda_pull_d;
    logic             busy_q, busy_d;
    logic             sending_q, sending_d;
    logic             held_q, held_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             stall;
    logic             tick;

`ifdef IIC_CLK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the quarter timer.
    assign stall = sck_q & ~scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall         = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (busy_q && !stall) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Commands are single-cycle pulses taken only while busy is low: start in IDLE,
    // stop > restart > start in HOLD; anything else is dropped without effect.
    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        dout_d     = dout_q;
        rw_d       = rw_q;
        ack_out_d  = ack_out_q;
        ack_bit_d  = ack_bit_q;
        sck_d      = sck_q;
        sda_pull_d = sda_pull_q;
        busy_d     = busy_q;
        sending_d  = sending_q;
        held_d     = held_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_START_A;
                    rw_d       = rw;
                    ack_out_d  = ack_out;
                    shreg_d    = din;
                    busy_d     = 1'b1;
                    ack_err_d  = 1'b0;
                    sck_d      = 1'b1;
                    sda_pull_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d    = ST_STOP_A;
                    busy_d     = 1'b1;
                    held_d     = 1'b0;
                    ack_err_d  = 1'b0;
                    sck_d      = 1'b0;
                    sda_pull_d = 1'b1;
                end else if (restart) begin
                    state_d    = ST_RS_A;
                    rw_d       = rw;
                    ack_out_d  = ack_out;
                    shreg_d    = din;
                    busy_d     = 1'b1;
                    held_d     = 1'b0;
                    ack_err_d  = 1'b0;
                    sck_d      = 1'b0;
                    sda_pull_d = 1'b0;
                end else if (start) begin
                    state_d    = ST_BIT;
                    bit_d      = 4'd0;
                    qtr_d      = 2'd0;
                    rw_d       = rw;
                    ack_out_d  = ack_out;
                    shreg_d    = din;
                    busy_d     = 1'b1;
                    held_d     = 1'b0;
                    ack_err_d  = 1'b0;
                    sending_d  = 1'b1;
                    sck_d      = 1'b0;
                    sda_pull_d = ~rw & ~din[7];
                end
            end
            ST_RS_A: begin
                if (tick) begin
                    state_d    = ST_START_A;
                    sck_d      = 1'b1;
                    sda_pull_d = 1'b0;
                end
            end
            ST_START_A: begin
                if (tick) begin
                    state_d    = ST_START_B;
                    sda_pull_d = 1'b1;
                end
            end
            ST_START_B: begin
                if (tick) begin
                    state_d    = ST_BIT;
                    bit_d      = 4'd0;
                    qtr_d      = 2'd0;
                    sending_d  = 1'b1;
                    sck_d      = 1'b0;
                    sda_pull_d = ~rw_q & ~shreg_q[7];
                end
            end
            ST_BIT: begin
                if (tick) begin
                    unique case (qtr_q)
                        2'd0: qtr_d = 2'd1;
                        2'd1: begin
                            qtr_d = 2'd2;
                            sck_d = 1'b1;
                        end
                        2'd2: begin
                            qtr_d = 2'd3;
                            if (bit_q == 4'd8) ack_bit_d = sda_in;
                            else               dout_d    = {dout_q[6:0], sda_in};
                        end
                        default: begin
                            qtr_d = 2'd0;
                            sck_d = 1'b0;
                            if (bit_q == 4'd8) begin
                                state_d   = ST_HOLD;
                                bit_d     = 4'd0;
                                busy_d    = 1'b0;
                                sending_d = 1'b0;
                                held_d    = 1'b1;
                                done_d    = 1'b1;
                                ack_err_d = ~rw_q & ack_bit_q;
                            end else begin
                                bit_d   = bit_q + 4'd1;
                                shreg_d = {shreg_q[6:0], 1'b0};
                                // Slot 8 is the ACK: released on write, ack_out level on read.
                                if (bit_q == 4'd7) sda_pull_d = rw_q & ~ack_out_q;
                                else               sda_pull_d = ~rw_q & ~shreg_q[6];
                            end
                        end
                    endcase
                end
            end
            ST_STOP_A: begin
                if (tick) begin
                    state_d = ST_STOP_B;
                    sck_d   = 1'b1;
                end
            end
            ST_STOP_B: begin
                if (tick) begin
                    state_d    = ST_STOP_C;
                    sda_pull_d = 1'b0;
                end
            end
            ST_STOP_C: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 4'd0;
            shreg_q    <= 8'd0;
            dout_q     <= 8'd0;
            rw_q       <= 1'b0;
            ack_out_q  <= 1'b0;
            ack_bit_q  <= 1'b0;
            sck_q      <= 1'b1;
            sda_pull_q <= 1'b0;
            busy_q     <= 1'b0;
            sending_q  <= 1'b0;
            held_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            rw_q       <= rw_d;
            ack_out_q  <= ack_out_d;
            ack_bit_q  <= ack_bit_d;
            sck_q      <= sck_d;
            sda_pull_q <= sda_pull_d;
            busy_q     <= busy_d;
            sending_q  <= sending_d;
            held_q     <= held_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign sending   = sending_q;
    assign held      = held_q;
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign sck       = sck_q;
    assign sda_pull  = sda_pull_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_iic_master.sv
// Directed bench for iic_master at CLK_DIV=2: a bus monitor decodes START/STOP/bits and a
// simple slave ACKs writes or drives read data; results are checked against hand-derived values.
module tb_iic_master;
    localparam int CLK_DIV = 2;
    localparam int BOUND   = 2000;

    logic       clock = 1'b0;
    logic       reset, start, restart, stop, rw, ack_out;
    logic [7:0] din, dout;
    logic       busy, sending, held, done, ack_err, sck, sda_pull, sda_in, scl_in;
    logic [3:0] state_dbg;

    logic       slave_pull, stretch;
    int         slave_mode;
    logic [7:0] slave_byte;

    int         bit_cnt = 0, slot = 0, start_cnt = 0, stop_cnt = 0;
    logic [7:0] rx_byte = 8'd0;
    logic       ack_seen = 1'b1, ack_pull = 1'b1, prev_sck = 1'b1, prev_sda = 1'b1;

    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clock = ~clock;

    iic_master #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .restart(restart), .stop(stop),
        .rw(rw), .ack_out(ack_out), .din(din), .dout(dout), .busy(busy),
        .sending(sending), .held(held), .done(done), .ack_err(ack_err), .sck(sck),
        .sda_pull(sda_pull), .sda_in(sda_in), .scl_in(scl_in), .state_dbg(state_dbg)
    );

    assign sda_in = ~(sda_pull | slave_pull);
    assign scl_in = sck & ~stretch;

    // Slave: mode 1 ACKs slot 8, mode 2 drives slave_byte in slots 0..7, mode 0 stays off the bus.
    always_comb begin
        slave_pull = 1'b0;
        if (slave_mode == 1)                  slave_pull = (slot == 8);
        else if (slave_mode == 2 && slot < 8) slave_pull = ~slave_byte[7 - slot];
    end

    always @(negedge clock) begin
        prev_sck <= sck;
        prev_sda <= sda_in;
        if (prev_sck && sck && prev_sda && !sda_in) begin
            start_cnt <= start_cnt + 1;
            bit_cnt   <= 0;
            slot      <= 0;
        end else if (prev_sck && sck && !prev_sda && sda_in) begin
            stop_cnt <= stop_cnt + 1;
        end else if (!prev_sck && sck) begin
            if (bit_cnt < 8) begin
                rx_byte <= {rx_byte[6:0], sda_in};
            end else begin
                ack_seen <= sda_in;
                ack_pull <= sda_pull;
            end
            bit_cnt <= (bit_cnt == 8) ? 0 : bit_cnt + 1;
        end else if (prev_sck && !sck) begin
            slot <= bit_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse one command, then count cycles until done (or until busy drops, for stop).
    task automatic run_cmd(input logic s, input logic rs, input logic sp, input logic r,
                           input logic ao, input logic [7:0] d, input logic wait_idle,
                           output int cyc, output int fp, output int sc, output logic err1);
        @(negedge clock);
        start = s; restart = rs; stop = sp; rw = r; ack_out = ao; din = d;
        cyc = 0; fp = -1; sc = 0; err1 = 1'bx;
        do begin
            @(negedge clock);
            cyc++;
            start = 1'b0; restart = 1'b0; stop = 1'b0;
            if (cyc == 1) err1 = ack_err;
            if (sda_pull && fp < 0) fp = cyc;
            if (sending) sc++;
        end while (!(wait_idle ? !busy : done) && cyc < BOUND);
        check("cmd_timeout", cyc < BOUND, 1);
    endtask

    initial begin
        int   cyc, fp, sc, k;
        logic e1;
`ifdef IIC_CLK_STRETCH_EN
        int   st;
`endif
        reset = 1'b1; start = 1'b0; restart = 1'b0; stop = 1'b0;
        rw = 1'b0; ack_out = 1'b0; din = 8'h00;
        stretch = 1'b0; slave_mode = 0; slave_byte = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_sck", sck, 1);
        check("rst_sda_pull", sda_pull, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_sending", sending, 0);
        check("rst_held", held, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_state", state_dbg, 0);

        // Write 0xAA from IDLE, slave ACKs.
        slave_mode = 1;
        run_cmd(1, 0, 0, 0, 0, 8'hAA, 0, cyc, fp, sc, e1);
        check("wr_aa_latency", cyc, 77);
        check("wr_aa_sda_fall", fp, 3);
        check("wr_aa_sending_cycles", sc, 72);
        check("wr_aa_bus_byte", rx_byte, 8'hAA);
        check("wr_aa_start_seen", start_cnt, 1);
        check("wr_aa_ack_on_bus", ack_seen, 0);
        check("wr_aa_ack_err", ack_err, 0);
        check("wr_aa_held", held, 1);
        check("wr_aa_busy", busy, 0);
        check("wr_aa_dout_readback", dout, 8'hAA);

        // Read 0x5A from HOLD with NACK, then STOP.
        slave_mode = 2; slave_byte = 8'h5A;
        run_cmd(1, 0, 0, 1, 1, 8'h00, 0, cyc, fp, sc, e1);
        check("rd_5a_latency", cyc, 73);
        check("rd_5a_dout", dout, 8'h5A);
        check("rd_5a_bus_byte", rx_byte, 8'h5A);
        check("rd_5a_master_ack_pull", ack_pull, 0);
        check("rd_5a_ack_on_bus", ack_seen, 1);
        check("rd_5a_ack_err", ack_err, 0);
        check("rd_5a_no_start", start_cnt, 1);
        check("rd_5a_sending_cycles", sc, 72);
        check("rd_5a_held", held, 1);
        slave_mode = 0;
        run_cmd(0, 0, 1, 0, 0, 8'h00, 1, cyc, fp, sc, e1);
        check("stop_latency", cyc, 7);
        check("stop_seen", stop_cnt, 1);
        check("stop_sck", sck, 1);
        check("stop_sda_pull", sda_pull, 0);
        check("stop_held", held, 0);
        check("stop_state", state_dbg, 0);

        // Write 0x55 with no slave ACK.
        run_cmd(1, 0, 0, 0, 0, 8'h55, 0, cyc, fp, sc, e1);
        check("nack_latency", cyc, 77);
        check("nack_ack_err", ack_err, 1);
        check("nack_bus_byte", rx_byte, 8'h55);
        check("nack_ack_on_bus", ack_seen, 1);
        check("nack_start_seen", start_cnt, 2);

        // Repeated START with 0xA1.
        slave_mode = 1;
        run_cmd(0, 1, 0, 0, 0, 8'hA1, 0, cyc, fp, sc, e1);
        check("rs_ack_err_cleared", e1, 0);
        check("rs_latency", cyc, 79);
        check("rs_start_seen", start_cnt, 3);
        check("rs_bus_byte", rx_byte, 8'hA1);
        check("rs_ack_err", ack_err, 0);
        run_cmd(0, 0, 1, 0, 0, 8'h00, 1, cyc, fp, sc, e1);
        check("stop2_seen", stop_cnt, 2);

        // Reset in the middle of bit 4 while SDA is driven low.
        @(negedge clock);
        start = 1'b1; rw = 1'b0; din = 8'h00;
        k = 0;
        do begin
            @(negedge clock);
            k++;
            start = 1'b0;
        end while (!(bit_cnt == 4 && !sck) && k < BOUND);
        check("mid_bit4_reached", k < BOUND, 1);
        check("mid_bit4_sda_pull", sda_pull, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_sck", sck, 1);
        check("mid_rst_sda_pull", sda_pull, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_held", held, 0);
        check("mid_rst_sending", sending, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_rst_no_stop", stop_cnt, 2);
        run_cmd(1, 0, 0, 0, 0, 8'h3C, 0, cyc, fp, sc, e1);
        check("post_rst_latency", cyc, 77);
        check("post_rst_bus_byte", rx_byte, 8'h3C);
        check("post_rst_start_seen", start_cnt, 5);
        check("post_rst_ack_err", ack_err, 0);
        check("post_rst_held", held, 1);

`ifdef IIC_CLK_STRETCH_EN
        // Slave stretches SCL for 10 clocks during bit 0.
        run_cmd(0, 0, 1, 0, 0, 8'h00, 1, cyc, fp, sc, e1);
        @(negedge clock);
        start = 1'b1; rw = 1'b0; din = 8'hAA;
        k = 0; st = 0;
        do begin
            @(negedge clock);
            k++;
            start = 1'b0;
            if (stretch) begin
                st++;
                if (st == 10) stretch = 1'b0;
            end else if (st == 0 && bit_cnt == 1 && sck) begin
                stretch = 1'b1;
            end
        end while (!done && k < BOUND);
        check("stretch_latency", k, 87);
        check("stretch_length", st, 10);
        check("stretch_bus_byte", rx_byte, 8'hAA);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
